display_scan_mux: RTL

Parametrised time-multiplexed driver for common-anode 7-segment display banks. It scans N digits, giving each an equal time slot. Each slot starts with a blanking guard against ghosting. The block decodes 4-bit hex values to active-low segments, honours a per-digit enable mask, and emits a frame strobe. It sits between the value registers (PWM duty and counters) and the board display pins, replacing the fixed 4-anode sweep.

---
 rtl/display_pkg.sv | 19 +
 rtl/hex7seg_decode.sv | 11 +
 rtl/display_scan_mux.sv | 131 +++++++++++++
 3 files changed

// File: rtl/display_pkg.sv
// Shared constants and types for the 7-segment scan driver.
package display_pkg;

  localparam int unsigned SEG_WIDTH = 7;
  localparam logic [SEG_WIDTH-1:0] SEG_OFF = 7'h7F;

  // Active-low {g,f,e,d,c,b,a} patterns, index = hex value (entry 15 listed first).
  localparam logic [15:0][SEG_WIDTH-1:0] SEG_LUT = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  typedef enum logic {ST_BLANK, ST_DRIVE} slot_state_t;

  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/hex7seg_decode.sv
// Combinational hex digit to active-low 7-segment pattern.
module hex7seg_decode
  import display_pkg::*;
(
  input  logic [3:0]           value,
  output logic [SEG_WIDTH-1:0] seg_n
);

  assign seg_n = SEG_LUT[value];

endmodule

// File: rtl/display_scan_mux.sv
// Time-multiplexed common-anode 7-segment scanner with blanking guard per slot.
// Optional LEADING_ZERO_BLANK_EN suppresses leading zero digits.
module display_scan_mux
  import display_pkg::*;
#(
  parameter  int unsigned N_DIGITS     = 4,
  parameter  int unsigned PRESCALE     = 50000,
  parameter  int unsigned BLANK_CYCLES = 16,
  localparam int unsigned SEL_W        = clog2_min1(N_DIGITS)
) (
  input  logic                   ck,
  input  logic                   rst,
  input  logic                   en,
  input  logic [4*N_DIGITS-1:0]  digit_data,
  input  logic [N_DIGITS-1:0]    dp_in,
  input  logic [N_DIGITS-1:0]    digit_mask,
  output logic [N_DIGITS-1:0]    an,
  output logic [SEG_WIDTH-1:0]   seg,
  output logic                   dp,
  output logic [SEL_W-1:0]       sel,
  output logic                   frame_tick
);

  localparam int unsigned PC_W = clog2_min1(PRESCALE);
  localparam logic [PC_W-1:0]  PC_LAST  = PC_W'(PRESCALE - 1);
  localparam logic [PC_W-1:0]  PC_BLANK = PC_W'(BLANK_CYCLES);
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(N_DIGITS - 1);

  logic [PC_W-1:0]      pc;
  logic [3:0]           lat_val;
  logic                 lat_dp;
  logic                 lat_show;

  logic [31:0]          sel_ext;
  logic [3:0]           live_val;
  logic                 live_dp;
  logic                 live_mask;
  logic                 live_show;
  logic [3:0]           eff_val;
  logic                 eff_dp;
  logic                 eff_show;
  logic [SEG_WIDTH-1:0] seg_pat;
  slot_state_t          slot_st;

  assign sel_ext = 32'(sel);

  always_comb begin
    live_val  = '0;
    live_dp   = 1'b0;
    live_mask = 1'b0;
    for (int unsigned i = 0; i < N_DIGITS; i++) begin
      if (sel_ext == i) begin
        live_val  = digit_data[4*i +: 4];
        live_dp   = dp_in[i];
        live_mask = digit_mask[i];
      end
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic upper_dark;

  always_comb begin
    upper_dark = 1'b1;
    for (int unsigned j = 0; j < N_DIGITS; j++) begin
      if (j > sel_ext && digit_data[4*j +: 4] != 4'd0 && digit_mask[j])
        upper_dark = 1'b0;
    end
  end

  assign live_show = live_mask && !(live_val == 4'd0 && upper_dark && sel != '0);
`else
  assign live_show = live_mask;
`endif

  // At pc==0 the latch is being loaded on this same edge, so drive from the live
  // selection; this keeps PRESCALE=1/BLANK_CYCLES=0 showing current data.
  assign eff_val  = (pc == '0) ? live_val  : lat_val;
  assign eff_dp   = (pc == '0) ? live_dp   : lat_dp;
  assign eff_show = (pc == '0) ? live_show : lat_show;
  assign slot_st  = (pc < PC_BLANK) ? ST_BLANK : ST_DRIVE;

  hex7seg_decode u_decode (
    .value (eff_val),
    .seg_n (seg_pat)
  );

  always_ff @(posedge ck) begin
    if (rst || !en) begin
      pc         <= '0;
      sel        <= '0;
      lat_val    <= '0;
      lat_dp     <= 1'b0;
      lat_show   <= 1'b0;
      an         <= '1;
      seg        <= SEG_OFF;
      dp         <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= 1'b0;
      if (pc == '0) begin
        lat_val  <= live_val;
        lat_dp   <= live_dp;
        lat_show <= live_show;
      end

      if (slot_st == ST_DRIVE && eff_show) begin
        an  <= ~(N_DIGITS'(1) << sel);
        seg <= seg_pat;
        dp  <= ~eff_dp;
      end else begin
        an  <= '1;
        seg <= SEG_OFF;
        dp  <= 1'b1;
      end

      if (pc == PC_LAST) begin
        pc <= '0;
        if (sel == SEL_LAST) begin
          sel        <= '0;
          frame_tick <= 1'b1;
        end else begin
          sel <= sel + 1'b1;
        end
      end else begin
        pc <= pc + 1'b1;
      end
    end
  end

endmodule
